// File: rtl/imm_ext_pkg.sv
// ============================================================================
// Module      : imm_ext_pkg
// Description : Shared mode encodings and occupancy states for imm_ext_pipe.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package imm_ext_pkg;

    localparam int IMM_MODE_W = 3;

    localparam logic [IMM_MODE_W-1:0] IMM_MODE_ZERO   = 3'd0;
    localparam logic [IMM_MODE_W-1:0] IMM_MODE_SIGN   = 3'd1;
    localparam logic [IMM_MODE_W-1:0] IMM_MODE_UPPER  = 3'd2;
    localparam logic [IMM_MODE_W-1:0] IMM_MODE_BRANCH = 3'd3;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } occ_state_t;

endpackage : imm_ext_pkg

`default_nettype wire

// File: rtl/imm_ext_core.sv
// ============================================================================
// Module      : imm_ext_core
// Description : Combinational immediate extender (zero/sign/upper/branch).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module imm_ext_core
    import imm_ext_pkg::*;
#(
    parameter int IMM_W    = 16,
    parameter int DATA_W   = 32,
    parameter int BR_SHIFT = 2
) (
    input  logic [IMM_W-1:0]      imm,
    input  logic [IMM_MODE_W-1:0] mode,
    output logic [DATA_W-1:0]     ext
);

    logic [DATA_W-1:0] w_zext;
    logic [DATA_W-1:0] w_sext;

    assign w_zext = DATA_W'(imm);
    assign w_sext = DATA_W'($signed(imm));

    // Illegal modes deliberately produce all-zero data.
    always_comb begin
        ext = '0;
        case (mode)
            IMM_MODE_ZERO:   ext = w_zext;
            IMM_MODE_SIGN:   ext = w_sext;
            IMM_MODE_UPPER:  ext = w_zext << (DATA_W - IMM_W);
            IMM_MODE_BRANCH: ext = w_sext << BR_SHIFT;
            default:         ext = '0;
        endcase
    end

endmodule : imm_ext_core

`default_nettype wire

// File: rtl/imm_ext_pipe.sv
// ============================================================================
// Module      : imm_ext_pipe
// Description : Registered immediate extender behind a 2-entry skid buffer.
//               Optional sticky illegal-mode flag: define IMMEXT_ERR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module imm_ext_pipe
    import imm_ext_pkg::*;
#(
    parameter int IMM_W    = 16,
    parameter int DATA_W   = 32,
    parameter int BR_SHIFT = 2,
    parameter int TAG_W    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IMM_W-1:0]      in_imm,
    input  logic [IMM_MODE_W-1:0] in_mode,
    input  logic [TAG_W-1:0]      in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_data,
    output logic [TAG_W-1:0]      out_tag,
    output logic                  err
);

    occ_state_t        r_state;
    occ_state_t        w_state_nxt;
    logic              r_in_ready;
    logic [DATA_W-1:0] r_out_data;
    logic [TAG_W-1:0]  r_out_tag;
    logic [DATA_W-1:0] r_skid_data;
    logic [TAG_W-1:0]  r_skid_tag;

    logic [DATA_W-1:0] w_ext;
    logic [TAG_W-1:0]  w_beat_tag;
    logic              w_acc;
    logic              w_drain;
    logic              w_load_out;
    logic              w_load_skid;
    logic              w_out_from_skid;

    imm_ext_core #(
        .IMM_W    (IMM_W),
        .DATA_W   (DATA_W),
        .BR_SHIFT (BR_SHIFT)
    ) u_core (
        .imm  (in_imm),
        .mode (in_mode),
        .ext  (w_ext)
    );

    assign out_valid = (r_state != ST_EMPTY);
    assign in_ready  = r_in_ready;
    assign out_data  = r_out_data;
    assign out_tag   = r_out_tag;
    assign w_acc     = in_valid & r_in_ready;
    assign w_drain   = out_valid & out_ready;

`ifdef IMMEXT_ERR_EN
    logic w_illegal;
    logic r_err;

    assign w_illegal = (in_mode > IMM_MODE_BRANCH);
    assign err       = r_err;

    // Tag MSB marks the offending beat so the consumer can locate it.
    always_comb begin
        w_beat_tag            = in_tag;
        w_beat_tag[TAG_W-1]   = in_tag[TAG_W-1] | w_illegal;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_acc && w_illegal) begin
            r_err <= 1'b1;
        end
    end
`else
    assign err        = 1'b0;
    assign w_beat_tag = in_tag;
`endif

    always_comb begin
        w_state_nxt     = r_state;
        w_load_out      = 1'b0;
        w_load_skid     = 1'b0;
        w_out_from_skid = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_acc) begin
                    w_state_nxt = ST_ONE;
                    w_load_out  = 1'b1;
                end
            end
            ST_ONE: begin
                if (w_acc && !w_drain) begin
                    w_state_nxt = ST_TWO;
                    w_load_skid = 1'b1;
                end else if (w_acc && w_drain) begin
                    w_load_out  = 1'b1;
                end else if (w_drain) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_TWO: begin
                // in_ready is low here, so only a drain can happen.
                if (w_drain) begin
                    w_state_nxt     = ST_ONE;
                    w_out_from_skid = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_data  <= '0;
            r_out_tag   <= '0;
            r_skid_data <= '0;
            r_skid_tag  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != ST_TWO);
            if (w_load_out) begin
                r_out_data <= w_ext;
                r_out_tag  <= w_beat_tag;
            end else if (w_out_from_skid) begin
                r_out_data <= r_skid_data;
                r_out_tag  <= r_skid_tag;
            end
            if (w_load_skid) begin
                r_skid_data <= w_ext;
                r_skid_tag  <= w_beat_tag;
            end
        end
    end

endmodule : imm_ext_pipe

`default_nettype wire

// File: tb/tb_imm_ext_pipe.sv
// ============================================================================
// Module      : tb_imm_ext_pipe
// Description : Directed, table-driven bench for imm_ext_pipe (default and
//               IMM_W=12/DATA_W=24/BR_SHIFT=1 instances).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_imm_ext_pipe;

    typedef struct {
        logic [15:0] imm;
        logic [2:0]  mode;
        logic [3:0]  tag;
        logic [31:0] exp;
    } vec_t;

    logic        clk;
    logic        rst_n;

    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_imm;
    logic [2:0]  in_mode;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_tag;
    logic        err;

    logic        p_in_valid;
    logic        p_in_ready;
    logic [11:0] p_in_imm;
    logic [2:0]  p_in_mode;
    logic [3:0]  p_in_tag;
    logic        p_out_valid;
    logic        p_out_ready;
    logic [23:0] p_out_data;
    logic [3:0]  p_out_tag;
    logic        p_err;

    int n_checks;
    int n_errors;

    vec_t tbl [8];
    vec_t ptbl [3];

    logic [3:0] exp_ill_tag;
    logic [31:0] exp_ill_err;

    imm_ext_pipe u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_imm    (in_imm),
        .in_mode   (in_mode),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .err       (err)
    );

    imm_ext_pipe #(
        .IMM_W    (12),
        .DATA_W   (24),
        .BR_SHIFT (1),
        .TAG_W    (4)
    ) u_dut_p (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (p_in_valid),
        .in_ready  (p_in_ready),
        .in_imm    (p_in_imm),
        .in_mode   (p_in_mode),
        .in_tag    (p_in_tag),
        .out_valid (p_out_valid),
        .out_ready (p_out_ready),
        .out_data  (p_out_data),
        .out_tag   (p_out_tag),
        .err       (p_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] imm, input logic [2:0] mode,
                         input logic [3:0] tag);
        in_valid = v;
        in_imm   = imm;
        in_mode  = mode;
        in_tag   = tag;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
`ifdef IMMEXT_ERR_EN
        exp_ill_tag = 4'hA;
        exp_ill_err = 32'd1;
`else
        exp_ill_tag = 4'h2;
        exp_ill_err = 32'd0;
`endif
        tbl[0] = '{16'h8000, 3'd1, 4'h1, 32'hFFFF8000};
        tbl[1] = '{16'h8000, 3'd0, 4'h2, 32'h00008000};
        tbl[2] = '{16'h1234, 3'd2, 4'h3, 32'h12340000};
        tbl[3] = '{16'hFFFF, 3'd3, 4'h4, 32'hFFFFFFFC};
        tbl[4] = '{16'h7FFF, 3'd3, 4'h5, 32'h0001FFFC};
        tbl[5] = '{16'h7FFF, 3'd1, 4'h6, 32'h00007FFF};
        tbl[6] = '{16'hFFFF, 3'd0, 4'h7, 32'h0000FFFF};
        tbl[7] = '{16'h00F0, 3'd2, 4'h8, 32'h00F00000};

        ptbl[0] = '{16'h0800, 3'd1, 4'h1, 32'h00FFF800};
        ptbl[1] = '{16'h0801, 3'd3, 4'h2, 32'h00FFF002};
        ptbl[2] = '{16'h0ABC, 3'd2, 4'h3, 32'h00ABC000};

        rst_n       = 1'b0;
        drive(1'b0, 16'h0, 3'd0, 4'h0);
        out_ready   = 1'b0;
        p_in_valid  = 1'b0;
        p_in_imm    = '0;
        p_in_mode   = '0;
        p_in_tag    = '0;
        p_out_ready = 1'b0;

        #12;
        chk("reset_in_ready",  {31'd0, in_ready},  32'd1);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_out_data",  out_data,           32'd0);
        chk("reset_out_tag",   {28'd0, out_tag},   32'd0);
        chk("reset_err",       {31'd0, err},       32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Mode table, out_ready held high: each beat visible one edge after acceptance.
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, tbl[i].imm, tbl[i].mode, tbl[i].tag);
            step();
            chk($sformatf("tbl%0d_valid", i), {31'd0, out_valid}, 32'd1);
            chk($sformatf("tbl%0d_data", i),  out_data,           tbl[i].exp);
            chk($sformatf("tbl%0d_tag", i),   {28'd0, out_tag},   {28'd0, tbl[i].tag});
        end
        drive(1'b0, 16'h0, 3'd0, 4'h0);
        step();
        chk("tbl_drained", {31'd0, out_valid}, 32'd0);

        // Back-pressure: three back-to-back beats with the consumer stalled.
        out_ready = 1'b0;
        drive(1'b1, 16'h0001, 3'd0, 4'h1);
        step();
        chk("bp_ready_after1", {31'd0, in_ready}, 32'd1);
        drive(1'b1, 16'h0002, 3'd0, 4'h2);
        step();
        chk("bp_ready_after2", {31'd0, in_ready}, 32'd0);
        chk("bp_hold_tag",     {28'd0, out_tag},  32'd1);
        drive(1'b1, 16'h0003, 3'd0, 4'h3);
        step();
        chk("bp_still_full",   {31'd0, in_ready}, 32'd0);
        chk("bp_hold_data",    out_data,          32'd1);
        chk("bp_hold_tag2",    {28'd0, out_tag},  32'd1);
        out_ready = 1'b1;
        step();
        chk("bp_out2_tag",     {28'd0, out_tag},  32'd2);
        chk("bp_out2_data",    out_data,          32'd2);
        chk("bp_ready_back",   {31'd0, in_ready}, 32'd1);
        step();
        chk("bp_out3_tag",     {28'd0, out_tag},  32'd3);
        chk("bp_out3_data",    out_data,          32'd3);
        drive(1'b0, 16'h0, 3'd0, 4'h0);
        step();
        chk("bp_empty",        {31'd0, out_valid}, 32'd0);

        // Streaming: one result per cycle, in_ready never drops.
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 16'(i + 16'h0100), 3'd0, 4'(i));
            step();
            chk($sformatf("stream%0d_data", i),  out_data,            32'(i + 32'h0100));
            chk($sformatf("stream%0d_ready", i), {31'd0, in_ready},   32'd1);
            chk($sformatf("stream%0d_valid", i), {31'd0, out_valid},  32'd1);
        end
        drive(1'b0, 16'h0, 3'd0, 4'h0);
        step();
        chk("stream_empty", {31'd0, out_valid}, 32'd0);

        // Illegal mode: beat still delivered as zero data.
        out_ready = 1'b0;
        drive(1'b1, 16'h00FF, 3'd5, 4'h2);
        step();
        drive(1'b0, 16'h0, 3'd0, 4'h0);
        chk("ill_valid", {31'd0, out_valid}, 32'd1);
        chk("ill_data",  out_data,           32'd0);
        chk("ill_tag",   {28'd0, out_tag},   {28'd0, exp_ill_tag});
        chk("ill_err",   {31'd0, err},       exp_ill_err);
        out_ready = 1'b1;
        step();
        drive(1'b1, 16'h0010, 3'd1, 4'h3);
        step();
        drive(1'b0, 16'h0, 3'd0, 4'h0);
        chk("ill_next_data", out_data,         32'h10);
        chk("ill_next_tag",  {28'd0, out_tag}, 32'h3);
        step();
        chk("ill_err_sticky", {31'd0, err}, exp_ill_err);

        // Asynchronous reset while holding two beats.
        out_ready = 1'b0;
        drive(1'b1, 16'h0009, 3'd0, 4'h9);
        step();
        drive(1'b1, 16'h000A, 3'd0, 4'hA);
        step();
        drive(1'b0, 16'h0, 3'd0, 4'h0);
        chk("rst_pre_full", {31'd0, in_ready}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_async_ready", {31'd0, in_ready},  32'd1);
        chk("rst_async_err",   {31'd0, err},       32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("rst_no_ghost%0d", i), {31'd0, out_valid}, 32'd0);
        end

        // Parameter sweep instance.
        p_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            p_in_valid = 1'b1;
            p_in_imm   = ptbl[i].imm[11:0];
            p_in_mode  = ptbl[i].mode;
            p_in_tag   = ptbl[i].tag;
            step();
            chk($sformatf("p%0d_valid", i), {31'd0, p_out_valid}, 32'd1);
            chk($sformatf("p%0d_data", i),  {8'd0, p_out_data},   ptbl[i].exp);
            chk($sformatf("p%0d_tag", i),   {28'd0, p_out_tag},   {28'd0, ptbl[i].tag});
        end
        p_in_valid = 1'b0;
        step();
        chk("p_empty", {31'd0, p_out_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_imm_ext_pipe

`default_nettype wire
